// File: rtl/garbage_inserter_if.sv
// Garbage inserter bus: garbage queueing, the batch start strobe, the playfield
// snapshot and all status outputs. The master drives requests and the slave
// (the inserter) returns the playfield and status.
interface garbage_inserter_if #(
    parameter int ROWS = 20,
    parameter int COLS = 10
);
    logic                 add_valid;
    logic [2:0]           add_count;
    logic                 insert_go;
    logic [ROWS*COLS-1:0] stored_array;
    logic [ROWS*COLS-1:0] garbage_array;
    logic [3:0]           pending;
    logic                 busy;
    logic                 done;
    logic                 top_out;

    modport master (
        output add_valid, add_count, insert_go, stored_array,
        input  garbage_array, pending, busy, done, top_out
    );

    modport slave (
        input  add_valid, add_count, insert_go, stored_array,
        output garbage_array, pending, busy, done, top_out
    );
endinterface

// File: rtl/garbage_inserter.sv
// Garbage row inserter. It pushes the playfield up one row per cycle and fills
// the bottom row with a garbage line. Each garbage line is full except for one
// hole column, and an LFSR picks that column. Row r occupies
// array[r*COLS +: COLS]. Row 0 is the top row.
// Optional feature: define GARBAGE_SAME_HOLE_EN to give every row of a batch
// the hole column of the first row. With this macro the LFSR advances once per
// batch.
module garbage_inserter #(
    parameter int         ROWS      = 20,
    parameter int         COLS      = 10,
    parameter int         MAX_PEND  = 15,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic             clk,
    input logic             reset_n,
    garbage_inserter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [ROWS*COLS-1:0] field;
    logic [3:0]           pend;
    logic [3:0]           batch;
    logic [7:0]           lfsr;
    logic                 busy;
    logic                 done;
    logic                 top_out;
`ifdef GARBAGE_SAME_HOLE_EN
    logic                 first;
    logic [3:0]           hole;
`endif

    logic                 top_hit;
    logic                 dec;
    logic [4:0]           pend_sum;
    logic [3:0]           pend_nxt;
    logic [3:0]           cur_hole;
    logic [COLS-1:0]      garb_row;
    logic                 fb;

    // Fold the LFSR nibble into the 0..9 column range.
    function automatic logic [3:0] hole_of(input logic [7:0] l);
        hole_of = (l[3:0] < 4'd10) ? l[3:0] : l[3:0] - 4'd10;
    endfunction

    // Compute the pending counter update, the hole column and the garbage row
    // for this cycle.
    always_comb begin
        top_hit  = (state == SHIFT) && (field[COLS-1:0] != '0);
        dec      = (state == SHIFT) && !top_hit;
        pend_sum = {1'b0, pend} + (bus.add_valid ? {2'b00, bus.add_count} : 5'd0)
                   - {4'd0, dec};
        pend_nxt = (pend_sum > 5'(MAX_PEND)) ? 4'(MAX_PEND) : pend_sum[3:0];
`ifdef GARBAGE_SAME_HOLE_EN
        cur_hole = first ? hole_of(lfsr) : hole;
`else
        cur_hole = hole_of(lfsr);
`endif
        garb_row = ~(COLS'(1) << cur_hole);
        fb       = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end

    // Batch FSM. It also holds the playfield, the pending counter and the
    // registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            field   <= '0;
            pend    <= '0;
            batch   <= '0;
            lfsr    <= LFSR_SEED;
            busy    <= 1'b0;
            done    <= 1'b0;
            top_out <= 1'b0;
`ifdef GARBAGE_SAME_HOLE_EN
            first   <= 1'b0;
            hole    <= '0;
`endif
        end else begin
            pend <= pend_nxt;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.insert_go) begin
                        // The batch takes the count from before this cycle's
                        // add. Lines that arrive later wait for the next
                        // insert_go.
                        field <= bus.stored_array;
                        batch <= pend;
                        busy  <= 1'b1;
`ifdef GARBAGE_SAME_HOLE_EN
                        first <= 1'b1;
`endif
                        if (pend != '0) begin
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (top_hit) begin
                        // Pushing now would eject a filled top row. Abort the
                        // batch and drop every queued line.
                        top_out <= 1'b1;
                        pend    <= '0;
                        batch   <= '0;
                        state   <= DONE;
                        done    <= 1'b1;
                    end else begin
                        field <= {garb_row, field[ROWS*COLS-1:COLS]};
                        batch <= batch - 4'd1;
`ifdef GARBAGE_SAME_HOLE_EN
                        first <= 1'b0;
                        hole  <= cur_hole;
                        if (first) lfsr <= {lfsr[6:0], fb};
`else
                        lfsr  <= {lfsr[6:0], fb};
`endif
                        if (batch == 4'd1) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.garbage_array = field;
    assign bus.pending       = pend;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.top_out       = top_out;
endmodule

// File: tb/tb_garbage_inserter.sv
// Directed bench for garbage_inserter. Inputs change on the falling edge, and
// outputs are sampled on the falling edge after the rising edge of interest.
module tb_garbage_inserter;
    localparam int W = 200;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    garbage_inserter_if #(.ROWS(20), .COLS(10)) bus ();

    garbage_inserter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Build a playfield whose rows 17..19 hold the given bits and whose other
    // rows are empty.
    function automatic logic [W-1:0] mk(input logic [9:0] r17, input logic [9:0] r18,
                                        input logic [9:0] r19);
        logic [W-1:0] v;
        v = '0;
        v[17*10 +: 10] = r17;
        v[18*10 +: 10] = r18;
        v[19*10 +: 10] = r19;
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic add(input logic [2:0] n);
        bus.add_valid = 1'b1;
        bus.add_count = n;
        step();
        bus.add_valid = 1'b0;
        bus.add_count = '0;
    endtask

    task automatic go(input logic [W-1:0] arr);
        bus.stored_array = arr;
        bus.insert_go    = 1'b1;
        step();
        bus.insert_go    = 1'b0;
    endtask

    initial begin
        logic [W-1:0] one_top;
        bus.add_valid    = 1'b0;
        bus.add_count    = '0;
        bus.insert_go    = 1'b0;
        bus.stored_array = '0;
        one_top          = '0;
        one_top[0]       = 1'b1;

        // Reset state, then five idle cycles.
        step(); step();
        check("rst_array", bus.garbage_array, '0);
        check("rst_busy", W'(bus.busy), '0);
        reset_n = 1'b1;
        repeat (5) step();
        check("idle_array", bus.garbage_array, '0);
        check("idle_pending", W'(bus.pending), '0);
        check("idle_busy", W'(bus.busy), '0);
        check("idle_done", W'(bus.done), '0);
        check("idle_topout", W'(bus.top_out), '0);

        // Two-line batch into an empty field. The holes are columns 5 and 0.
        add(3'd2);
        check("b2_pending", W'(bus.pending), W'(2));
        go('0);
        check("b2_c1_busy", W'({bus.busy, bus.done}), W'(2'b10));
        step();
        check("b2_c2_busy", W'({bus.busy, bus.done}), W'(2'b10));
        step();
        check("b2_c3_done", W'({bus.busy, bus.done}), W'(2'b11));
`ifdef GARBAGE_SAME_HOLE_EN
        check("b2_rows", bus.garbage_array, mk(10'h000, 10'h3DF, 10'h3DF));
`else
        check("b2_rows", bus.garbage_array, mk(10'h000, 10'h3DF, 10'h3FE));
`endif
        check("b2_pending0", W'(bus.pending), '0);
        step();
        check("b2_idle", W'({bus.busy, bus.done}), W'(2'b00));

        // Top-out: the top row is occupied, so the field does not shift.
        add(3'd1);
        go(one_top);
        step();
        check("to_done", W'(bus.done), W'(1));
        check("to_flag", W'(bus.top_out), W'(1));
        check("to_pending", W'(bus.pending), '0);
        check("to_array", bus.garbage_array, one_top);
        step();
        go('0);
        check("to_go0_done", W'(bus.done), W'(1));
        check("to_sticky", W'(bus.top_out), W'(1));
        check("to_go0_array", bus.garbage_array, '0);
        step();

        // The pending counter saturates at 15.
        add(3'd7);
        add(3'd7);
        check("sat_14", W'(bus.pending), W'(14));
        add(3'd3);
        check("sat_15", W'(bus.pending), W'(15));
        add(3'd7);
        check("sat_hold", W'(bus.pending), W'(15));

        // A plain reset clears the pending count and the sticky top_out.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rst2_topout", W'(bus.top_out), '0);
        check("rst2_pending", W'(bus.pending), '0);

        // An asynchronous reset partway through a 3-line batch.
        add(3'd3);
        go('0);
        step();
        check("ab_pending2", W'(bus.pending), W'(2));
        #2 reset_n = 1'b0;
        #1;
        check("ab_array", bus.garbage_array, '0);
        check("ab_flags", W'({bus.pending, bus.busy, bus.done, bus.top_out}), '0);
        step();
        reset_n = 1'b1;
        add(3'd2);
        go('0);
        step(); step();
        check("ab_done", W'(bus.done), W'(1));
`ifdef GARBAGE_SAME_HOLE_EN
        check("ab_rows", bus.garbage_array, mk(10'h000, 10'h3DF, 10'h3DF));
`else
        check("ab_rows", bus.garbage_array, mk(10'h000, 10'h3DF, 10'h3FE));
`endif
        step();

        // Lines added during a running batch wait for the next batch.
        add(3'd2);
        go('0);
        check("cc_p2", W'(bus.pending), W'(2));
        bus.add_valid = 1'b1;
        bus.add_count = 3'd3;
        step();
        bus.add_valid = 1'b0;
        bus.add_count = '0;
        check("cc_p4", W'(bus.pending), W'(4));
        step();
        check("cc_p3", W'(bus.pending), W'(3));
        check("cc_done", W'(bus.done), W'(1));
`ifdef GARBAGE_SAME_HOLE_EN
        check("cc_rows", bus.garbage_array, mk(10'h000, 10'h3FE, 10'h3FE));
`else
        check("cc_rows", bus.garbage_array, mk(10'h000, 10'h3DF, 10'h3FE));
`endif
        step();
        check("cc_idle", W'(bus.busy), '0);
        go('0);
        step(); step();
        check("n3_notdone", W'(bus.done), '0);
        step();
        check("n3_done", W'(bus.done), W'(1));
`ifdef GARBAGE_SAME_HOLE_EN
        check("n3_rows", bus.garbage_array, mk(10'h3DF, 10'h3DF, 10'h3DF));
`else
        check("n3_rows", bus.garbage_array, mk(10'h3EF, 10'h1FF, 10'h3F7));
`endif
        check("n3_pending", W'(bus.pending), '0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/garbage_inserter.md
Name: garbage_inserter

Overview:
- Inverse of the line-clear path: pushes the playfield up from the bottom and inserts garbage rows, each fully filled except for one hole column.
- Garbage lines are queued by an external source (e.g. opponent clears) and inserted as a batch when the game FSM pulses insert_go after landing.
- Row 0 is the top row and row ROWS-1 the bottom; bit c of a row is column c.
- Flags top-out if a push would eject a non-empty top row.

Parameters:
- ROWS, 20, playfield rows
- COLS, 10, playfield columns (hole mapping below assumes 10)
- MAX_PEND, 15, saturation limit of the pending-line counter (4-bit counter)
- LFSR_SEED, 8'hA5, reset value of the hole LFSR; must be nonzero

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- add_valid  in  1  queue add_count garbage lines this cycle
- add_count  in  3  number of lines to queue (0-7)
- insert_go  in  1  start batch insertion; sampled only in IDLE
- stored_array  in  ROWS*COLS  playfield snapshot, sampled when insert_go is accepted
- garbage_array  out  ROWS*COLS  resulting playfield
- pending  out  4  queued lines not yet inserted
- busy  out  1  high when state is not IDLE
- done  out  1  one-cycle completion pulse
- top_out  out  1  sticky overflow flag

Behaviour:
- Reset (async, reset_n=0):
  - garbage_array=0, pending=0, busy=0, done=0, top_out=0.
  - lfsr=LFSR_SEED, state=IDLE, batch=0.
- Pending counter update, every cycle:
  - pending_next = pending - dec + (add_valid ? add_count : 0), saturating at MAX_PEND.
  - dec=1 on a SHIFT cycle that inserts a row.
  - Simultaneous add and decrement both apply in the same cycle.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On insert_go: garbage_array<=stored_array and batch<=pending (value before this cycle's add).
  - Go to SHIFT if pending!=0, else DONE.
  - Lines added during a batch are not part of it; they wait for the next insert_go.
- SHIFT, one row per cycle:
  - If garbage_array row 0 != 0: top_out<=1, pending<=0, batch<=0, array unchanged, go to DONE.
  - Otherwise: new row k = old row k+1 for k<ROWS-1; new row ROWS-1 = all ones except bit h.
  - lfsr advances; batch decrements; go to DONE when batch reaches 0.
- Hole column: h = lfsr[3:0] if lfsr[3:0]<10, else lfsr[3:0]-10. h uses the lfsr value before advancing.
- LFSR advance: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE.
  - garbage_array holds until the next accepted insert_go.
- Latency: done is high B+1 cycles after the edge that accepts insert_go, where B = batch. With pending=0, done is high the next cycle.
- Edge cases:
  - insert_go while busy is ignored.
  - top_out clears only on reset.
  - Reset mid-batch aborts immediately to the reset values.

Optional Feature:
- Macro GARBAGE_SAME_HOLE_EN.
- Defined: lfsr advances once per batch, on the first inserted row; every row in the batch shares that first row's hole column.
- Undefined: lfsr advances on every inserted row, as above.

Test Plan:
- Reset, then hold idle 5 cycles -> all outputs 0, pending=0, busy=0.
- add_valid=1, add_count=2; stored_array all zero; then insert_go -> busy for 3 cycles; done high 3 cycles after the go edge; row 18=10'h3DF (hole 5), row 19=10'h3FE (hole 0), other rows 0; pending=0.
- Stored row 0=10'h001, pending=1, insert_go -> no shift, top_out=1, pending=0, garbage_array=stored_array, done pulses; top_out stays 1 after a later insert_go.
- pending=14, add_count=3 -> pending=15; a further add_count=7 -> still 15.
- Batch of 2 running, add_valid with add_count=3 on the first SHIFT cycle -> pending goes 2→4→3; only 2 rows inserted; the next insert_go inserts 3 more.
- reset_n low during SHIFT of a 3-line batch -> outputs return to reset values asynchronously; lfsr=8'hA5; the next batch reproduces the first-row hole 5.
- With GARBAGE_SAME_HOLE_EN, same stimulus as the 2-line case -> rows 18 and 19 both 10'h3DF.
